// File: rtl/board_wb_arbiter.sv
// Two-master Wishbone arbiter for the board slave: M0 = game logic, M1 = VGA drawer.
// Round-robin on ties, ownership held for the whole cycle, abort on slave timeout.
`timescale 1ns / 1ps

module board_wb_arbiter #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    // Master 0 (game logic)
    input  logic              m0_cyc,
    input  logic              m0_stb,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_adr,
    input  logic [DATA_W-1:0] m0_dat_w,
    output logic [DATA_W-1:0] m0_dat_r,
    output logic              m0_ack,
    output logic              m0_err,
    // Master 1 (VGA board drawer)
    input  logic              m1_cyc,
    input  logic              m1_stb,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_adr,
    input  logic [DATA_W-1:0] m1_dat_w,
    output logic [DATA_W-1:0] m1_dat_r,
    output logic              m1_ack,
    output logic              m1_err,
    // Slave
    output logic              s_cyc,
    output logic              s_stb,
    output logic              s_we,
    output logic [ADDR_W-1:0] s_adr,
    output logic [DATA_W-1:0] s_dat_w,
    input  logic [DATA_W-1:0] s_dat_r,
    input  logic              s_ack,
    // Current owner, one-hot; 00 when idle or aborting
    output logic [1:0]        grant
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // Value the counter holds in the stalled cycle that would make it reach TIMEOUT
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StOwn0,
        StOwn1,
        StAbort
    } state_t;

    state_t           state;
    logic             last_grant;  // 0 = M0 was served last, 1 = M1
    logic [CNT_W-1:0] wait_cnt;
    logic             own_cyc;
    logic             own_is_m1;

    // Owner's cyc line and identity, used by the FSM to detect release
    always_comb begin
        own_is_m1 = (state == StOwn1);
        own_cyc   = own_is_m1 ? m1_cyc : m0_cyc;
    end

    // Arbitration FSM with registered grant, round-robin memory and stall counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= StIdle;
            last_grant <= 1'b1;
            wait_cnt   <= '0;
            grant      <= 2'b00;
        end else begin
            case (state)
                StIdle: begin
                    wait_cnt <= '0;
                    // M0 wins when alone, or on a tie when M1 was served last
                    if (m0_cyc && (!m1_cyc || last_grant)) begin
                        state <= StOwn0;
                        grant <= 2'b01;
                    end else if (m1_cyc) begin
                        state <= StOwn1;
                        grant <= 2'b10;
                    end
                end
                StOwn0, StOwn1: begin
                    if (!own_cyc) begin
                        state      <= StIdle;
                        grant      <= 2'b00;
                        last_grant <= own_is_m1;
                        wait_cnt   <= '0;
                    end else if (s_ack) begin
                        // An ack in the would-be timeout cycle still completes the beat
                        wait_cnt <= '0;
                    end else if (s_stb) begin
                        if (wait_cnt == CNT_LAST) begin
                            state      <= StAbort;
                            grant      <= 2'b00;
                            last_grant <= own_is_m1;
                            wait_cnt   <= '0;
                        end else begin
                            wait_cnt <= wait_cnt + CNT_W'(1);
                        end
                    end
                end
                StAbort: begin
                    state    <= StIdle;
                    grant    <= 2'b00;
                    wait_cnt <= '0;
                end
                default: begin
                    state    <= StIdle;
                    grant    <= 2'b00;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    // Bus steering: owner drives the slave, the other master sees all zeros
    always_comb begin
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_adr    = '0;
        s_dat_w  = '0;
        m0_dat_r = '0;
        m0_ack   = 1'b0;
        m0_err   = 1'b0;
        m1_dat_r = '0;
        m1_ack   = 1'b0;
        m1_err   = 1'b0;
        unique case (state)
            StOwn0: begin
                s_cyc    = m0_cyc;
                s_stb    = m0_stb;
                s_we     = m0_we;
                s_adr    = m0_adr;
                s_dat_w  = m0_dat_w;
                m0_dat_r = s_dat_r;
                m0_ack   = s_ack & m0_stb;
            end
            StOwn1: begin
                s_cyc    = m1_cyc;
                s_stb    = m1_stb;
                s_we     = m1_we;
                s_adr    = m1_adr;
                s_dat_w  = m1_dat_w;
                m1_dat_r = s_dat_r;
                m1_ack   = s_ack & m1_stb;
            end
            StAbort: begin
                // last_grant was loaded with the aborted owner on entry
                m0_err = ~last_grant;
                m1_err = last_grant;
            end
            default: ;
        endcase
    end

endmodule
